mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates the single shared main-memory port between the instruction cache and the data cache of the pipelined RISC-V core. It sequences each miss/write-back transaction through a three-state controller and holds the memory command stable until memory acknowledges. It returns read data and a one-cycle ready pulse to the winning cache. It sits between the two cache controllers and the memory model, so each cache sees a private memory interface.

## Interface
- ADDR_W, 28, line address width (word address of a 128-bit line)
- DATA_W, 128, line data width
---
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous reset, active-high
- i_read  in  1  I-cache line read request; held until i_ready
- i_addr  in  ADDR_W  I-cache line address
- i_ready  out  1  one-cycle pulse, I-cache transaction done
- i_rdata  out  DATA_W  read line for I-cache; valid while i_ready
- d_read  in  1  D-cache line read request
- d_write  in  1  D-cache line write request
- d_addr  in  ADDR_W  D-cache line address
- d_wdata  in  DATA_W  D-cache write line
- d_ready  out  1  one-cycle pulse, D-cache transaction done
- d_rdata  out  DATA_W  read line for D-cache; valid while d_ready
- mem_read  out  1  memory read command
- mem_write  out  1  memory write command
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ready  in  1  memory done; rdata valid when the command was a read
- mem_rdata  in  DATA_W  memory read line

## Operation
- States: IDLE, BUSY, RESP. Owner register: I or D.
- IDLE: evaluate requests. d_req = d_read|d_write; i_req = i_read. If neither is set, stay in IDLE. If exactly one is set, grant it. If both are set, apply the arbitration policy (see Configuration). On grant, register the owner's command onto mem_* and go to BUSY.
- D command encoding: d_write=1 gives mem_write=1 with mem_wdata=d_wdata. Otherwise mem_read=1. d_read and d_write both set is illegal; write wins.
- I grants always produce mem_read=1. mem_wdata keeps its last value (don't-care).
- BUSY: hold mem_read, mem_write, mem_addr and mem_wdata unchanged. When mem_ready is sampled high:
  - capture mem_rdata into the read register
  - clear mem_read and mem_write
  - set the owner's ready
  - go to RESP
- RESP: the owner's ready is high for exactly this cycle. The non-owner's ready stays 0. Next state is IDLE, unconditionally.
- i_rdata and d_rdata are both driven from the single read register. For a D write, the read register is not updated.
- mem_ready is ignored in IDLE and RESP.
- If a requester drops its request mid-transaction, the transaction still completes and the ready pulse is still issued.
- Only one memory command is outstanding at a time. mem_read and mem_write are never high together.

## Timing
- Reset (async, immediate): state=IDLE. The following outputs and registers are all 0: mem_read, mem_write, mem_addr, mem_wdata, i_ready, d_ready, read register, owner. The round-robin pointer resets to "last=D".
- Reset during BUSY abandons the memory transaction. No ready pulse is issued.
- Request sampled high in IDLE at edge N: mem command visible after edge N.
- mem_ready sampled at edge M: ready/rdata high during cycle M..M+1, IDLE after M+1.
- Minimum turnaround: 3 cycles from request to ready, with mem_ready returned 1 cycle after the command.
- Between transactions there is one IDLE cycle, so back-to-back grants are spaced by at least one command-free cycle.
- Requesters must deassert their request (or present a new one) in the cycle after their ready pulse.

## Configuration
- ARB_RR_EN defined: round-robin on contention.
  - On simultaneous i_req and d_req in IDLE, grant the requester that did not win the last contended grant.
  - The pointer updates only on contended grants.
  - After reset the first contention goes to I.
- ARB_RR_EN undefined: fixed priority. D always wins contention, and the I-cache can be starved by continuous D traffic.

## Test plan
- I read alone: i_read=1, i_addr=0x0000100, memory acks 4 cycles later with 0xDEAD…BEEF. Expect mem_read=1 and mem_addr=0x0000100 held for 4 cycles, then i_ready pulses for 1 cycle with i_rdata=0xDEAD…BEEF, and d_ready stays 0.
- D write alone: d_write=1, d_addr=0x0000200, d_wdata=0x1234…5678. Expect mem_write=1 with that addr/data held until mem_ready, then a d_ready pulse, and the read register unchanged.
- Contention without ARB_RR_EN: i_read and d_read both asserted continuously. Expect every grant to go to D and i_ready never to pulse.
- Contention with ARB_RR_EN: same stimulus. Expect grants in the order I, D, I, D, with each ready going to the matching owner.
- Spurious and illegal inputs:
  - mem_ready=1 while IDLE: no ready pulse and no state change.
  - d_read=d_write=1: expect mem_write=1 and mem_read=0.
- Reset mid-BUSY: assert rst 2 cycles into a D read. Expect all outputs 0 in the same cycle, no d_ready pulse, and a fresh request after rst deasserts to be served normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundles the I-cache, D-cache and main-memory handshake signals seen by mem_arbiter.
// The slave modport is the arbiter's view; master is the view of the environment
// (caches plus memory model) that drives requests and acknowledges.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned DATA_W = 128
);
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ready;
    logic [DATA_W-1:0] i_rdata;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ready;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_ready, mem_rdata,
        output i_ready, i_rdata, d_ready, d_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_ready, mem_rdata,
        input  i_ready, i_rdata, d_ready, d_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one main-memory line port between the I-cache and the D-cache.
// One transaction at a time: IDLE (grant) -> BUSY (command held until mem_ready)
// -> RESP (one-cycle ready pulse to the owner) -> IDLE.
// Define ARB_RR_EN for round-robin on contention; otherwise D has fixed priority.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned DATA_W = 128
) (
    input logic           clk,
    input logic           rst,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;          // 1: D-cache owns the port
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              i_ready_q, i_ready_d;
    logic              d_ready_q, d_ready_d;
`ifdef ARB_RR_EN
    logic              last_d_q, last_d_d;        // 1: D won the last contended grant
`endif

    logic d_req;
    logic i_req;
    logic grant_d;

    // Next-state, grant and memory-command logic
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;
`ifdef ARB_RR_EN
        last_d_d    = last_d_q;
`endif
        d_req   = bus.d_read | bus.d_write;
        i_req   = bus.i_read;
        grant_d = d_req;

        unique case (state_q)
            IDLE: begin
`ifdef ARB_RR_EN
                if (d_req && i_req) begin
                    grant_d  = ~last_d_q;
                    last_d_d = ~last_d_q;
                end
`endif
                if (d_req || i_req) begin
                    owner_d = grant_d;
                    state_d = BUSY;
                    if (grant_d) begin
                        mem_addr_d = bus.d_addr;
                        if (bus.d_write) begin
                            mem_write_d = 1'b1;
                            mem_read_d  = 1'b0;
                            mem_wdata_d = bus.d_wdata;
                        end else begin
                            mem_write_d = 1'b0;
                            mem_read_d  = 1'b1;
                        end
                    end else begin
                        mem_addr_d  = bus.i_addr;
                        mem_write_d = 1'b0;
                        mem_read_d  = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (bus.mem_ready) begin
                    if (mem_read_q) begin
                        rdata_d = bus.mem_rdata;
                    end
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    i_ready_d   = ~owner_q;
                    d_ready_d   = owner_q;
                    state_d     = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
`ifdef ARB_RR_EN
            last_d_q    <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
`ifdef ARB_RR_EN
            last_d_q    <= last_d_d;
`endif
        end
    end

    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_ready   = i_ready_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.i_rdata   = rdata_q;
    assign bus.d_rdata   = rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table (inputs for the cycle,
// expected outputs after the following rising edge) plus a hand-written
// reset-during-BUSY sequence. Expected contention order depends on ARB_RR_EN.
module tb_mem_arbiter;
    localparam int unsigned AW = 28;
    localparam int unsigned DW = 128;

    typedef struct {
        logic          ir;
        logic [AW-1:0] ia;
        logic          dr;
        logic          dw;
        logic [AW-1:0] da;
        logic [DW-1:0] dwd;
        logic          mr;
        logic [DW-1:0] mrd;
        logic          e_mr;
        logic          e_mw;
        logic [AW-1:0] e_ma;
        logic [DW-1:0] e_mwd;
        logic          e_ir;
        logic          e_dr;
        logic [DW-1:0] e_rd;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic ir, input logic [AW-1:0] ia, input logic dr, input logic dw,
                       input logic [AW-1:0] da, input logic [DW-1:0] dwd,
                       input logic mr, input logic [DW-1:0] mrd,
                       input logic emr, input logic emw, input logic [AW-1:0] ema,
                       input logic [DW-1:0] emwd, input logic eir, input logic edr,
                       input logic [DW-1:0] erd);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd;
        v.mr = mr; v.mrd = mrd;
        v.e_mr = emr; v.e_mw = emw; v.e_ma = ema; v.e_mwd = emwd;
        v.e_ir = eir; v.e_dr = edr; v.e_rd = erd;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] A, B, C, IA, DA, E, F;
        logic [DW-1:0] DB, W, W2, J1, J2, RF, rk, prev;
        logic          own_d [4];
        logic          seen_dr;
        int            n;
        vec_t          v;

        A  = 28'h0000100; B = 28'h0000200; C = 28'h0000280;
        IA = 28'h0000300; DA = 28'h0000400; E = 28'h0000500; F = 28'h0000600;
        DB = 128'hDEAD0000_11111111_22222222_0000BEEF;
        W  = 128'h12340000_AAAAAAAA_55555555_00005678;
        W2 = 128'h0F0F0F0F_F0F0F0F0_0F0F0F0F_F0F0F0F0;
        J1 = 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0;
        J2 = 128'h0BAD0BAD_0BAD0BAD_0BAD0BAD_0BAD0BAD;
        RF = 128'hFEEDFACE_CAFEF00D_01234567_89ABCDEF;
`ifdef ARB_RR_EN
        own_d = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        own_d = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

        //   ir ia  dr dw da dwd  mr mrd  | mr mw ma  mwd  ir dr rdata
        add(0, 0,  0, 0, 0, 0,   0, 0,    0, 0, 0,  0,   0, 0, 0);   // idle
        add(0, 0,  0, 0, 0, 0,   1, J1,   0, 0, 0,  0,   0, 0, 0);   // spurious mem_ready
        add(1, A,  0, 0, 0, 0,   0, 0,    1, 0, A,  0,   0, 0, 0);   // I read granted
        add(1, A,  0, 0, 0, 0,   0, 0,    1, 0, A,  0,   0, 0, 0);
        add(1, A,  0, 0, 0, 0,   0, 0,    1, 0, A,  0,   0, 0, 0);
        add(1, A,  0, 0, 0, 0,   0, 0,    1, 0, A,  0,   0, 0, 0);
        add(1, A,  0, 0, 0, 0,   1, DB,   0, 0, 0,  0,   1, 0, DB);  // ack -> i_ready
        add(0, 0,  0, 0, 0, 0,   1, J2,   0, 0, 0,  0,   0, 0, DB);  // RESP ignores mem_ready
        add(0, 0,  0, 1, B, W,   0, 0,    0, 1, B,  W,   0, 0, DB);  // D write granted
        add(0, 0,  0, 1, B, W,   0, 0,    0, 1, B,  W,   0, 0, DB);
        add(0, 0,  0, 1, B, W,   1, J1,   0, 0, 0,  0,   0, 1, DB);  // write ack, rdata kept
        add(0, 0,  0, 0, 0, 0,   0, 0,    0, 0, 0,  0,   0, 0, DB);
        add(0, 0,  1, 1, C, W2,  0, 0,    0, 1, C,  W2,  0, 0, DB);  // read+write: write wins
        add(0, 0,  1, 1, C, W2,  1, J2,   0, 0, 0,  0,   0, 1, DB);
        add(0, 0,  0, 0, 0, 0,   0, 0,    0, 0, 0,  0,   0, 0, DB);
        prev = DB;
        for (int k = 0; k < 4; k++) begin
            rk = {4{32'hC0DE0000 + 32'(k)}};
            add(1, IA, 1, 0, DA, 0, 0, 0,  1, 0, own_d[k] ? DA : IA, 0, 0, 0, prev);
            add(1, IA, 1, 0, DA, 0, 1, rk, 0, 0, 0, 0, ~own_d[k], own_d[k], rk);
            add(1, IA, 1, 0, DA, 0, 0, 0,  0, 0, 0, 0, 0, 0, rk);
            prev = rk;
        end

        bus.i_read = 0; bus.i_addr = '0; bus.d_read = 0; bus.d_write = 0;
        bus.d_addr = '0; bus.d_wdata = '0; bus.mem_ready = 0; bus.mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst mem_read",  bus.mem_read, 0);
        chk("rst mem_write", bus.mem_write, 0);
        chk("rst mem_addr",  bus.mem_addr, 0);
        chk("rst mem_wdata", bus.mem_wdata, 0);
        chk("rst i_ready",   bus.i_ready, 0);
        chk("rst d_ready",   bus.d_ready, 0);
        chk("rst rdata",     bus.i_rdata, 0);
        rst = 0;

        for (int k = 0; k < vecs.size(); k++) begin
            v = vecs[k];
            bus.i_read = v.ir; bus.i_addr = v.ia; bus.d_read = v.dr; bus.d_write = v.dw;
            bus.d_addr = v.da; bus.d_wdata = v.dwd; bus.mem_ready = v.mr; bus.mem_rdata = v.mrd;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d mem_read", k),  bus.mem_read, v.e_mr);
            chk($sformatf("v%0d mem_write", k), bus.mem_write, v.e_mw);
            if (v.e_mr || v.e_mw) chk($sformatf("v%0d mem_addr", k), bus.mem_addr, v.e_ma);
            if (v.e_mw) chk($sformatf("v%0d mem_wdata", k), bus.mem_wdata, v.e_mwd);
            chk($sformatf("v%0d i_ready", k), bus.i_ready, v.e_ir);
            chk($sformatf("v%0d d_ready", k), bus.d_ready, v.e_dr);
            chk($sformatf("v%0d i_rdata", k), bus.i_rdata, v.e_rd);
            chk($sformatf("v%0d d_rdata", k), bus.d_rdata, v.e_rd);
        end

        // Reset two cycles into a D read
        bus.i_read = 0; bus.d_write = 0; bus.mem_ready = 0;
        bus.d_read = 1; bus.d_addr = E;
        @(posedge clk);
        #1;
        chk("rb cmd", bus.mem_read, 1);
        chk("rb addr", bus.mem_addr, E);
        @(posedge clk);
        #1;
        bus.mem_ready = 1; bus.mem_rdata = J1; rst = 1;
        #1;
        chk("rb mem_read",  bus.mem_read, 0);
        chk("rb mem_write", bus.mem_write, 0);
        chk("rb mem_addr",  bus.mem_addr, 0);
        chk("rb mem_wdata", bus.mem_wdata, 0);
        chk("rb i_ready",   bus.i_ready, 0);
        chk("rb d_ready",   bus.d_ready, 0);
        chk("rb rdata",     bus.d_rdata, 0);
        bus.d_read = 0;
        seen_dr = 0;
        @(posedge clk);
        #1;
        rst = 0; bus.mem_ready = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.d_ready) seen_dr = 1;
        end
        chk("rb no d_ready", seen_dr, 0);

        // Fresh I request after reset is served normally
        bus.i_read = 1; bus.i_addr = F;
        n = 0;
        while (!bus.mem_read && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("fresh cmd", bus.mem_read, 1);
        chk("fresh latency", n, 1);
        chk("fresh addr", bus.mem_addr, F);
        bus.mem_ready = 1; bus.mem_rdata = RF;
        @(posedge clk);
        #1;
        bus.mem_ready = 0; bus.i_read = 0;
        chk("fresh i_ready", bus.i_ready, 1);
        chk("fresh d_ready", bus.d_ready, 0);
        chk("fresh i_rdata", bus.i_rdata, RF);
        @(posedge clk);
        #1;
        chk("fresh pulse end", bus.i_ready, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
